// File: rtl/crc32_frame_tx.sv
// crc32_frame_tx
// Byte-stream framer: forwards payload bytes from the packet source to the
// serial link and appends a CRC-32/MPEG-2 (poly 04C11DB7, init FFFFFFFF,
// MSB-first, no reflection, no final XOR) after the last payload byte.
// Valid/ready on both sides, single output register, 1 byte/cycle sustained.
// Frames longer than MAX_LEN are cut at MAX_LEN; the source tail is swallowed.

module crc32_frame_tx #(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             crc_en_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic             len_err_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = '1;

  // byte_cnt must hold MAX_LEN itself (value right after a forced end)
  localparam int unsigned     BC_W     = $clog2(MAX_LEN + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CRC,
    ST_DONE,
    ST_DROP
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            en_r;
  logic            en_nxt;
  logic            trunc_r;
  logic [BC_W-1:0] byte_cnt;
  logic [1:0]      crc_k;
  logic [31:0]     crc_r;

  logic            slot_free;
  logic            at_max;
  logic            load_pay;
  logic            load_crc;
  logic            pay_last;
  logic            trunc_set;
  logic [7:0]      crc_byte;

  // One MSB-first CRC step over a whole byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic [7:0]  d;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[31] ^ d[7]) begin
        c = {c[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
      d = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  // Frame sequencing: next state, source handshake and output-load strobes.
  always_comb begin
    slot_free = !m_valid_o || m_ready_i;
    at_max    = (byte_cnt == LAST_IDX);
    state_nxt = state;
    en_nxt    = en_r;
    load_pay  = 1'b0;
    load_crc  = 1'b0;
    pay_last  = 1'b0;
    trunc_set = 1'b0;
    s_ready_o = 1'b0;

    unique case (state)
      ST_IDLE, ST_PAYLOAD: begin
        s_ready_o = slot_free;
        if (s_valid_i && slot_free) begin
          load_pay = 1'b1;
          // crc_en_i only matters on the first byte of a frame
          if (state == ST_IDLE) begin
            en_nxt = crc_en_i;
          end
          // byte_cnt is 0 in IDLE, so at_max there covers MAX_LEN == 1
          if (s_last_i || at_max) begin
            trunc_set = !s_last_i;
            pay_last  = !en_nxt;
            state_nxt = en_nxt ? ST_CRC : ST_DONE;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end

      ST_CRC: begin
        if (slot_free) begin
          load_crc = 1'b1;
          if (crc_k == 2'd3) begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_nxt = trunc_r ? ST_DROP : ST_IDLE;
      end

      ST_DROP: begin
        // swallow the source tail of a truncated frame, no output, no CRC
        s_ready_o = 1'b1;
        if (s_valid_i && s_last_i) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // CRC byte currently due on the link, most significant byte first.
  always_comb begin
    unique case (crc_k)
      2'd0:    crc_byte = crc_r[31:24];
      2'd1:    crc_byte = crc_r[23:16];
      2'd2:    crc_byte = crc_r[15:8];
      default: crc_byte = crc_r[7:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Per-frame bookkeeping: CRC accumulator, byte/CRC counters, flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_r        <= 1'b0;
      trunc_r     <= 1'b0;
      crc_r       <= CRC_INIT;
      byte_cnt    <= '0;
      crc_k       <= '0;
      frame_cnt_o <= '0;
      len_err_o   <= 1'b0;
    end else begin
      en_r      <= en_nxt;
      len_err_o <= trunc_set;

      if (trunc_set) begin
        trunc_r <= 1'b1;
      end else if (state == ST_DONE) begin
        trunc_r <= 1'b0;
      end

      if (state == ST_DONE) begin
        crc_r       <= CRC_INIT;
        byte_cnt    <= '0;
        crc_k       <= '0;
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end else begin
        if (load_pay) begin
          crc_r    <= crc32_byte(crc_r, s_data_i);
          byte_cnt <= byte_cnt + BC_W'(1);
        end
        if (load_crc) begin
          crc_k <= crc_k + 2'd1;
        end
      end
    end
  end

  // Output register: loads payload or CRC bytes; holds while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (load_pay) begin
      m_valid_o <= 1'b1;
      m_data_o  <= s_data_i;
      m_last_o  <= pay_last;
    end else if (load_crc) begin
      m_valid_o <= 1'b1;
      m_data_o  <= crc_byte;
      m_last_o  <= (crc_k == 2'd3);
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc32_frame_tx.sv
// tb_crc32_frame_tx
// Scoreboard bench: the driver pushes the expected output beats of each frame
// (from a table-driven CRC model) before driving it; a negedge monitor pops
// and compares on every output handshake and also owns all other checks.

module tb_crc32_frame_tx;

  localparam int unsigned MAX_LEN = 12;
  localparam int unsigned CNT_W   = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             crc_en_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [7:0]       s_data_i;
  logic             s_last_i;
  logic             m_valid_o;
  logic             m_ready_i = 1'b1;
  logic [7:0]       m_data_o;
  logic             m_last_o;
  logic             len_err_o;
  logic [CNT_W-1:0] frame_cnt_o;

  crc32_frame_tx #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .crc_en_i   (crc_en_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .len_err_o  (len_err_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  int          errors       = 0;
  int          checks       = 0;
  int          len_err_seen = 0;
  int          exp_len_err  = 0;
  int          exp_frames   = 0;
  bit          rnd_ready    = 1'b0;
  logic [8:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  chk_t        chk_q[$];
  logic [31:0] tbl[256];

  // monitor-private
  chk_t        mc;
  logic [8:0]  me;
  logic [8:0]  stall_val;
  bit          stall_pending = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] idx;
    idx = c[31:24] ^ b;
    return (c << 8) ^ tbl[idx];
  endfunction

  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = crc_step(c, b[i]);
    return c;
  endfunction

  task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      checks++;
      if (mc.act !== mc.exp) begin
        errors++;
        $display("FAIL %s: got %0h, need %0h", mc.name, mc.act, mc.exp);
      end
    end
    if (!rst_n_i) begin
      exp_q.delete();
      stall_pending = 1'b0;
    end else begin
      if (len_err_o) len_err_seen++;
      if (stall_pending && m_valid_o) begin
        checks++;
        if ({m_last_o, m_data_o} !== stall_val) begin
          errors++;
          $display("FAIL stall_hold: got %h, need %h", {m_last_o, m_data_o}, stall_val);
        end
      end
      stall_pending = m_valid_o && !m_ready_i;
      stall_val     = {m_last_o, m_data_o};
      if (m_valid_o && m_ready_i) begin
        obs_q.push_back(m_data_o);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got last=%b data=%h, need no beat", m_last_o, m_data_o);
        end else begin
          me = exp_q.pop_front();
          if ({m_last_o, m_data_o} !== me) begin
            errors++;
            $display("FAIL beat: got last=%b data=%h, need last=%b data=%h",
                     m_last_o, m_data_o, me[8], me[7:0]);
          end
        end
      end
    end
  end

  // ---------------- downstream ready ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      m_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] d, input bit last, input bit en);
    int unsigned t;
    t = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    crc_en_i  = en;
    forever begin
      @(negedge clk_i);
      if (s_ready_o) begin
        @(posedge clk_i);
        #1;
        break;
      end
      t++;
      if (t > 1000) begin
        push_chk("accept_timeout", {31'b0, s_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit en);
    int unsigned n;
    logic [31:0] c;
    n = (pl.size() > MAX_LEN) ? MAX_LEN : pl.size();
    c = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < n; i++) begin
      c = crc_step(c, pl[i]);
      exp_q.push_back({(!en && (i == n - 1)), pl[i]});
    end
    if (en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        exp_q.push_back({(k == 3), 8'(c >> (24 - 8 * k))});
      end
    end
    exp_frames++;
    if (pl.size() > MAX_LEN) exp_len_err++;
    for (int unsigned i = 0; i < pl.size(); i++) begin
      // crc_en_i after the first byte is random: it must be ignored
      send_byte(pl[i], (i == pl.size() - 1), (i == 0) ? en : 1'($urandom_range(0, 1)));
      if (i != pl.size() - 1 && $urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    if (exp_q.size() != 0) push_chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic check_counts(input string tag);
    push_chk({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(exp_frames % (1 << CNT_W)));
    push_chk({tag, "_len_err"}, len_err_seen, exp_len_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    push_chk({tag, "_m_valid"}, {31'b0, m_valid_o}, 32'd0);
    push_chk({tag, "_m_data"}, {24'b0, m_data_o}, 32'd0);
    push_chk({tag, "_m_last"}, {31'b0, m_last_o}, 32'd0);
    push_chk({tag, "_len_err"}, {31'b0, len_err_o}, 32'd0);
    push_chk({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  tail[$];
    logic [31:0] c;
    int unsigned n;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i) << 24;
      repeat (8) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      tbl[i] = c;
    end

    rst_n_i   = 1'b0;
    crc_en_i  = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // check string, full throughput
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    send_frame(pl, 1'b1);
    drain();
    n = obs_q.size();
    push_chk("check_crc", {obs_q[n-4], obs_q[n-3], obs_q[n-2], obs_q[n-1]}, 32'h0376_E6E7);
    check_counts("t1");

    // same frame under random backpressure
    rnd_ready = 1'b1;
    send_frame(pl, 1'b1);
    drain();
    check_counts("t2");

    // single zero byte: residue of payload+CRC is zero
    pl.delete();
    pl.push_back(8'h00);
    send_frame(pl, 1'b1);
    drain();
    n = obs_q.size();
    tail.delete();
    for (int unsigned i = n - 5; i < n; i++) tail.push_back(obs_q[i]);
    push_chk("residue", ref_crc(tail), 32'h0000_0000);
    check_counts("t3");

    // bypass
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'hBB);
    pl.push_back(8'hCC);
    send_frame(pl, 1'b0);
    drain();
    check_counts("t4");

    // truncation at MAX_LEN, then a clean frame
    pl.delete();
    for (int unsigned i = 0; i < MAX_LEN + 2; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1'b1);
    drain();
    check_counts("t5a");
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1'b1);
    drain();
    check_counts("t5b");

    // reset while the second CRC byte is on the link
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1'b1);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_frames = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    pl.delete();
    for (int i = 0; i < 7; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1'b1);
    drain();
    check_counts("t6");

    // random frames: lengths straddle MAX_LEN, counter wraps
    for (int f = 0; f < 40; f++) begin
      rnd_ready = 1'($urandom_range(0, 1));
      pl.delete();
      n = $urandom_range(1, MAX_LEN + 4);
      for (int unsigned i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_frame(pl, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk_i);
        #1;
      end
      drain();
      check_counts("rnd");
    end

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
